// File: rtl/music_sequencer_if.sv
// rtl/music_sequencer_if.sv - control/status bundle between song controller and music_sequencer.
interface music_sequencer_if #(
   parameter int NOTE_W = 20,
   parameter int ADDR_W = 5
);
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [NOTE_W-1:0] wr_data;
   logic              start;
   logic              stop;
   logic              loop;
   logic [ADDR_W-1:0] last_addr;
   logic [1:0]        octave;
   logic              audio_out;
   logic              busy;
   logic [ADDR_W-1:0] note_addr;
   logic              done;

   modport master (
      output wr_en, wr_addr, wr_data, start, stop, loop, last_addr, octave,
      input  audio_out, busy, note_addr, done
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, start, stop, loop, last_addr, octave,
      output audio_out, busy, note_addr, done
   );
endinterface

// File: rtl/music_sequencer.sv
// rtl/music_sequencer.sv - note table sequencer driving a square-wave tone output.
module music_sequencer #(
   parameter int NOTE_W     = 20,
   parameter int ADDR_W     = 5,
   parameter int NOTE_TICKS = 12_500_000,
   parameter int GAP_TICKS  = 1_250_000
) (
   input  logic              clk,
   input  logic              rst,
   music_sequencer_if.slave  bus
);
   localparam int MAX_T = (NOTE_TICKS > GAP_TICKS) ? NOTE_TICKS : GAP_TICKS;
   localparam int CNT_W = $clog2(MAX_T + 1);
   localparam logic [CNT_W-1:0] NOTE_LAST = CNT_W'(NOTE_TICKS - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = (GAP_TICKS > 0) ? CNT_W'(GAP_TICKS - 1) : '0;

   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_PLAY, S_GAP, S_DONE} state_t;

   state_t            r_state;
   state_t            w_state_next;
   logic [NOTE_W-1:0] r_mem [2**ADDR_W];
   logic [NOTE_W-1:0] r_dout;
   logic [NOTE_W-1:0] r_period;
   logic [NOTE_W-1:0] r_tone;
   logic [NOTE_W-1:0] w_shifted;
   logic [NOTE_W-1:0] w_period_load;
   logic [ADDR_W-1:0] r_note_addr;
   logic [ADDR_W-1:0] r_last;
   logic [ADDR_W-1:0] w_addr_next;
   logic [CNT_W-1:0]  r_dur;
   logic              r_audio;
   logic              w_note_end;
   logic              w_gap_end;
   logic              w_advance;

   // Table read address is always note_addr; the read register gives read-before-write.
   always_ff @(posedge clk) begin
      if (bus.wr_en) begin
         r_mem[bus.wr_addr] <= bus.wr_data;
      end
      r_dout <= r_mem[r_note_addr];
   end

   assign w_shifted     = r_dout >> bus.octave;
   assign w_period_load = (r_dout != '0 && w_shifted == '0) ? NOTE_W'(1) : w_shifted;
   assign w_note_end    = (r_state == S_PLAY) && (r_dur == NOTE_LAST);
   assign w_gap_end     = (r_state == S_GAP) && (r_dur == GAP_LAST);
   assign w_advance     = (GAP_TICKS == 0) ? w_note_end : w_gap_end;

   always_comb begin
      w_state_next = r_state;
      w_addr_next  = r_note_addr;
      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_state_next = S_FETCH;
               w_addr_next  = '0;
            end
         end
         S_FETCH: w_state_next = S_LOAD;
         S_LOAD:  w_state_next = S_PLAY;
         S_PLAY: begin
            if (w_note_end && GAP_TICKS != 0) begin
               w_state_next = S_GAP;
            end
         end
         S_GAP:   w_state_next = S_GAP;
         S_DONE:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
      if (w_advance) begin
         if (r_note_addr != r_last) begin
            w_addr_next  = r_note_addr + 1'b1;
            w_state_next = S_FETCH;
         end else if (bus.loop) begin
            w_addr_next  = '0;
            w_state_next = S_FETCH;
         end else begin
            w_state_next = S_DONE;
         end
      end
      if (bus.stop) begin
         w_state_next = S_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_note_addr <= '0;
         r_last      <= '0;
         r_period    <= '0;
         r_tone      <= '0;
         r_dur       <= '0;
         r_audio     <= 1'b0;
      end else begin
         r_state <= w_state_next;
         if (!bus.stop) begin
            r_note_addr <= w_addr_next;
         end
         if (r_state == S_IDLE && bus.start && !bus.stop) begin
            r_last <= bus.last_addr;
         end
         case (r_state)
            S_LOAD: begin
               r_period <= w_period_load;
               r_tone   <= '0;
               r_dur    <= '0;
               r_audio  <= 1'b0;
            end
            S_PLAY: begin
               r_dur <= w_note_end ? '0 : r_dur + 1'b1;
               // A zero period is a rest: hold the wave low and the counter parked.
               if (r_period == '0) begin
                  r_tone  <= '0;
                  r_audio <= 1'b0;
               end else if (r_tone == r_period - NOTE_W'(1)) begin
                  r_tone  <= '0;
                  r_audio <= ~r_audio;
               end else begin
                  r_tone <= r_tone + 1'b1;
               end
               if (w_note_end) begin
                  r_audio <= 1'b0;
               end
            end
            S_GAP: begin
               r_dur   <= w_gap_end ? '0 : r_dur + 1'b1;
               r_audio <= 1'b0;
            end
            default: begin
               r_dur <= '0;
            end
         endcase
         if (bus.stop) begin
            r_audio <= 1'b0;
         end
      end
   end

   assign bus.audio_out = r_audio;
   assign bus.busy      = (r_state != S_IDLE);
   assign bus.done      = (r_state == S_DONE);
   assign bus.note_addr = r_note_addr;
endmodule

// File: tb/tb_music_sequencer.sv
// tb/tb_music_sequencer.sv - directed self-checking bench for music_sequencer.
module tb_music_sequencer;
   localparam int NOTE_W = 20;
   localparam int ADDR_W = 2;

   logic clk = 1'b0;
   logic rst;
   int   n_assert = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   music_sequencer_if #(.NOTE_W(NOTE_W), .ADDR_W(ADDR_W)) bus ();

   music_sequencer #(
      .NOTE_W(NOTE_W), .ADDR_W(ADDR_W), .NOTE_TICKS(8), .GAP_TICKS(2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input int a, input int d);
      bus.wr_en   = 1'b1;
      bus.wr_addr = a[ADDR_W-1:0];
      bus.wr_data = d[NOTE_W-1:0];
      tick();
      bus.wr_en   = 1'b0;
   endtask

   // Called in the FETCH cycle of a note; returns in the cycle after its last GAP cycle.
   task automatic expect_note(input int a, input int per, input bit drop_loop,
                              input bit wr_fetch, input bit wr_play, input int wa, input int wd);
      int e;
      chk("fetch_addr", 32'(bus.note_addr), 32'(a));
      chk("fetch_busy", 32'(bus.busy), 32'd1);
      chk("fetch_done", 32'(bus.done), 32'd0);
      if (wr_fetch) begin
         bus.wr_en = 1'b1; bus.wr_addr = wa[ADDR_W-1:0]; bus.wr_data = wd[NOTE_W-1:0];
      end
      tick();
      bus.wr_en = 1'b0;
      if (drop_loop) bus.loop = 1'b0;
      tick();
      for (int j = 0; j < 8; j++) begin
         e = (per == 0) ? 0 : ((j / per) % 2);
         chk($sformatf("play_audio_a%0d_j%0d", a, j), 32'(bus.audio_out), 32'(e));
         if (j == 0 && wr_play) begin
            bus.wr_en = 1'b1; bus.wr_addr = wa[ADDR_W-1:0]; bus.wr_data = wd[NOTE_W-1:0];
         end
         tick();
         bus.wr_en = 1'b0;
      end
      for (int g = 0; g < 2; g++) begin
         chk("gap_audio", 32'(bus.audio_out), 32'd0);
         chk("gap_busy", 32'(bus.busy), 32'd1);
         tick();
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
      chk({tag, "_done"}, 32'(bus.done), 32'd0);
      chk({tag, "_audio"}, 32'(bus.audio_out), 32'd0);
   endtask

   initial begin
      rst = 1'b1;
      bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
      bus.start = 1'b0; bus.stop = 1'b0; bus.loop = 1'b0;
      bus.last_addr = '0; bus.octave = '0;
      repeat (3) tick();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk_idle("reset");
         chk("reset_addr", 32'(bus.note_addr), 32'd0);
         tick();
      end

      // Single tone, period 3.
      wr(0, 3);
      bus.last_addr = 2'd0; bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      expect_note(0, 3, 0, 0, 0, 0, 0);
      chk("single_done", 32'(bus.done), 32'd1);
      chk("single_done_busy", 32'(bus.busy), 32'd1);
      tick();
      chk_idle("single_after");

      // Rest, clamp and octave shift.
      wr(0, 0); wr(1, 1); wr(2, 4); wr(3, 2);
      bus.octave = 2'd2; bus.last_addr = 2'd3; bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      expect_note(0, 0, 0, 0, 0, 0, 0);
      expect_note(1, 1, 0, 0, 0, 0, 0);
      expect_note(2, 1, 0, 0, 0, 0, 0);
      expect_note(3, 1, 0, 0, 0, 0, 0);
      chk("oct_done", 32'(bus.done), 32'd1);
      tick();
      chk_idle("oct_after");

      // Loop with wrap, then drop loop during entry 3 of the second pass.
      bus.octave = 2'd0; bus.loop = 1'b1; bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      expect_note(0, 0, 0, 0, 0, 0, 0);
      expect_note(1, 1, 0, 0, 0, 0, 0);
      expect_note(2, 4, 0, 0, 0, 0, 0);
      expect_note(3, 2, 0, 0, 0, 0, 0);
      expect_note(0, 0, 0, 0, 0, 0, 0);
      expect_note(1, 1, 0, 0, 0, 0, 0);
      expect_note(2, 4, 0, 0, 0, 0, 0);
      expect_note(3, 2, 1, 0, 0, 0, 0);
      chk("loop_done", 32'(bus.done), 32'd1);
      tick();
      chk_idle("loop_after");

      // Stop during PLAY.
      wr(0, 3);
      bus.last_addr = 2'd0; bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      repeat (6) tick();
      chk("stop_pre_audio", 32'(bus.audio_out), 32'd1);
      bus.stop = 1'b1;
      tick();
      bus.stop = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk_idle("stop_after");
         tick();
      end

      // start and stop together.
      bus.start = 1'b1; bus.stop = 1'b1;
      tick();
      bus.start = 1'b0; bus.stop = 1'b0;
      chk_idle("start_stop");

      // start while busy is ignored and last_addr is not relatched.
      wr(1, 1);
      bus.last_addr = 2'd1; bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      repeat (3) tick();
      bus.start = 1'b1; bus.last_addr = 2'd0;
      tick();
      bus.start = 1'b0;
      chk("busy_start_addr", 32'(bus.note_addr), 32'd0);
      chk("busy_start_busy", 32'(bus.busy), 32'd1);
      repeat (8) tick();
      chk("busy_start_next_addr", 32'(bus.note_addr), 32'd1);
      chk("busy_start_next_done", 32'(bus.done), 32'd0);
      bus.stop = 1'b1;
      tick();
      bus.stop = 1'b0;
      chk_idle("busy_start_stop");

      // Writes during playback: new data seen, same-cycle-as-FETCH write not seen.
      bus.last_addr = 2'd1; bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      expect_note(0, 3, 0, 0, 1, 1, 2);
      expect_note(1, 2, 0, 1, 0, 1, 5);
      chk("wr_done", 32'(bus.done), 32'd1);
      tick();
      chk_idle("wr_after");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/music_sequencer.md
# music_sequencer

Parametrised note sequencer and square-wave tone generator for the audio path. It holds a writable note table of half-period counts (clock cycles per half wave). On start it steps through entries 0..last_addr, one fixed-length note each, with an articulation gap between notes. Options are loop mode and an octave shift. It replaces the fixed per-song note ROMs: the controller loads a song, then starts it, and `audio_out` drives the speaker pin.

## Interface
Parameters:
- `NOTE_W`, 20: width of a half-period count.
- `ADDR_W`, 5: note table address width. Depth is 2^ADDR_W.
- `NOTE_TICKS`, 12_500_000: cycles each note sounds (250 ms at 50 MHz).
- `GAP_TICKS`, 1_250_000: silent cycles after each note. 0 means no gap.

Ports:
- `clk` in 1: system clock (50 MHz). One clock domain.
- `rst` in 1: synchronous, active-high reset.
- `wr_en` in 1: note table write strobe.
- `wr_addr` in ADDR_W: write address.
- `wr_data` in NOTE_W: half-period count. 0 means rest.
- `start` in 1: start playback. Single-cycle pulse.
- `stop` in 1: abort playback.
- `loop` in 1: restart at entry 0 after last_addr. Sampled at each wrap decision.
- `last_addr` in ADDR_W: final entry of the song. Sampled on accepted start.
- `octave` in 2: right-shift applied to the period (pitch up 0..3 octaves). Sampled in LOAD.
- `audio_out` out 1: square wave.
- `busy` out 1: high in any state except IDLE.
- `note_addr` out ADDR_W: table entry currently being played.
- `done` out 1: one-cycle pulse on non-loop completion.

## Operation
- Table: 2^ADDR_W x NOTE_W, contents undefined after configuration.
  - Synchronous write. Synchronous read with 1-cycle latency.
  - Read-before-write: a write and a read of the same address in one cycle return the old data.
  - Writes are allowed at any time. rst does not clear the table.
- FSM states: IDLE, FETCH, LOAD, PLAY, GAP, DONE.
- IDLE: `start` is accepted when stop=0.
  - Latch last_addr, set note_addr=0, go to FETCH.
  - `start` while busy is ignored.
- FETCH (1 cycle): present note_addr to the table, go to LOAD.
- LOAD (1 cycle): latch period.
  - period = dout >> octave.
  - If dout != 0 and the shifted result is 0, clamp period to 1.
  - Clear the tone counter and the duration counter. Go to PLAY.
- PLAY (NOTE_TICKS cycles): tone counter counts 0..period-1.
  - At period-1, toggle audio_out and return the counter to 0.
  - period = 0 (rest): audio_out held 0, counter held 0.
  - After NOTE_TICKS cycles, go to GAP, or go straight to the advance decision if GAP_TICKS=0.
- GAP (GAP_TICKS cycles): audio_out forced 0, then the advance decision.
- Advance decision:
  - note_addr != last_addr: note_addr+1, go to FETCH.
  - note_addr == last_addr with loop=1: note_addr=0, go to FETCH.
  - note_addr == last_addr with loop=0: go to DONE.
- DONE (1 cycle): done=1, go to IDLE.
- `stop`: from any state, the next state is IDLE, audio_out=0, no done pulse. stop beats start in the same cycle.
- Address wrap: with last_addr = 2^ADDR_W-1 the increment never overflows, because the advance decision resets note_addr to 0.

## Timing
- Reset values:
  - state IDLE.
  - audio_out=0, busy=0, done=0, note_addr=0.
  - All counters 0, period 0.
- rst mid-playback behaves as stop: outputs take their reset values on the next edge.
- Start acceptance: start is sampled at edge k.
  - busy=1 after edge k, state FETCH.
  - LOAD follows at k+1, PLAY at k+2.
- Per-note length: 2 + NOTE_TICKS + GAP_TICKS cycles (FETCH, LOAD, PLAY, GAP).
- Tone: audio_out is 0 on entry to PLAY. The first toggle comes `period` cycles after PLAY entry. Full wave = 2*period cycles.
- Completion: done pulses the cycle after the last GAP cycle. busy falls one cycle after done.
- Table update latency: data written before the FETCH cycle of an entry is used for that entry.

## Test plan
Bench parameters: ADDR_W=2, NOTE_TICKS=8, GAP_TICKS=2.
- Reset and idle: hold rst 3 cycles, then release -> all outputs 0, and they stay 0 with no start.
- Single tone:
  - Stimulus: write entry0=3, last_addr=0, loop=0, start.
  - Response: audio_out toggles every 3 PLAY cycles (0,0,0,1,1,1,0,0). It is 0 during the 2 GAP cycles.
  - done pulses 12 cycles after busy rises. busy=0 one cycle later.
- Rest, clamp and octave:
  - Entries {0,1,4,2}, octave=2, last_addr=3.
  - Entry0 stays silent.
  - Entry1 clamps to period 1, so audio_out toggles every cycle.
  - Entry2 is period 1, entry3 is period 1 (clamped).
  - note_addr steps 0..3 at 12-cycle spacing.
- Loop and wrap:
  - last_addr=3, loop=1, run 60 cycles: note_addr sequence 0,1,2,3,0 with no done pulse.
  - Deassert loop during entry 3: one more pass is not started, and done fires after entry 3.
- Stop and contention:
  - stop during PLAY -> next cycle IDLE, audio_out=0, done=0.
  - start and stop asserted together -> remains IDLE.
  - start while busy -> ignored, and note_addr is unchanged.
- Write during playback:
  - Rewrite entry1 during entry0's PLAY: the new value is heard.
  - A write to entry1 in the same cycle as its FETCH: the old value is heard.
